ceespu_mem_arbiter: RTL and testbench
=====================================

Name: ceespu_mem_arbiter

Overview:
Shares one single-port synchronous 32-bit RAM between the ceespu instruction-fetch port and data port. Each cycle it grants the RAM to one requester. It drives the losing side's busy flag and routes the RAM's one-cycle-latency read data back to the winner. It sits between the ceespu core and the unified BRAM, replacing the separate imem and dmem models. A starvation counter guarantees fetch progress under back-to-back data traffic.

Parameters:
ADDR_W, 14, RAM word-address width (16384 words = 64 KiB)
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win a conflict

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_addr  in  16  fetch byte address
imem_en  in  1  fetch request
imem_reset  in  1  clear fetch data output
imem_data  out  32  fetched instruction
imem_busy  out  1  fetch not granted this cycle
dmem_addr  in  16  data byte address
dmem_en  in  1  data request
dmem_we  in  4  byte write enables (0 = read)
dmem_wdata  in  32  write data
dmem_rdata  out  32  load data
dmem_busy  out  1  data access not granted this cycle
mem_addr  out  ADDR_W  RAM word address
mem_en  out  1  RAM enable
mem_we  out  4  RAM byte write enables
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid cycle after mem_en

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. While rst is high:
  - imem_data = 0, dmem_rdata = 0, grant_q = NONE, starve_cnt = 0.
  - mem_en = 0 and mem_we = 0, combinationally forced.
  - imem_busy = 0 and dmem_busy = 0.
- Grant is combinational from the current-cycle requests:
  - Only imem_en set: IMEM wins.
  - Only dmem_en set: DMEM wins.
  - Both set: DMEM wins, unless starve_cnt == STARVE_MAX, in which case IMEM wins.
  - Neither set: NONE.
- Busy flags, combinational in the same cycle:
  - imem_busy = imem_en & grant!=IMEM.
  - dmem_busy = dmem_en & grant!=DMEM.
  - A requester holds its request and address stable while busy.
- RAM drive:
  - mem_en = grant!=NONE.
  - mem_addr = winner's byte address bits [ADDR_W+1:2]. Upper address bits are ignored, so addresses alias/wrap modulo RAM size. Bits [1:0] are ignored.
  - mem_we = dmem_we when grant==DMEM, else 0.
  - mem_wdata = dmem_wdata.
- Read latency 1 cycle:
  - grant_q registers {grant, read flag}.
  - Cycle after an IMEM grant: imem_data <= mem_rdata.
  - Cycle after a DMEM read grant (dmem_we==0): dmem_rdata <= mem_rdata.
  - DMEM writes do not update dmem_rdata.
  - Outputs hold their value otherwise.
- imem_reset:
  - At the next edge, imem_data <= 0 and any pending IMEM return is discarded.
  - Takes precedence over an in-flight fetch return.
  - If fetch is requested in the same cycle, it is still granted, but its data is dropped.
- State machine grant_q: NONE / IMEM / IMEM_KILL / DMEM_RD / DMEM_WR.
  - grant_q is next-state equal to this cycle's grant.
  - It selects the return path only.
- Starvation counter, 3 bits minimum (clog2(STARVE_MAX+1)):
  - Increments when imem_en & grant==DMEM.
  - Clears when grant==IMEM or imem_en==0.
  - Saturates at STARVE_MAX.
- Reset asserted mid-access: the pending return is discarded, and no data output updates in the following cycle.
- No combinational path from mem_rdata to any output.

Decomposition:
- Shared package ceespu_pkg:
  - grant_q state encoding constants (GNT_NONE, GNT_IMEM, GNT_IMEM_KILL, GNT_DMEM_RD, GNT_DMEM_WR).
  - Default ADDR_W.
- Sub-module ceespu_starve_cnt (saturating counter, inputs inc/clr, output at_max): natural, but optional.

Test Plan:
- Reset then imem_en=1, imem_addr=0x0008 with RAM word2=0xDEADBEEF -> mem_addr=2 same cycle; imem_data=0xDEADBEEF next cycle; imem_busy=0 throughout.
- imem_en and dmem_en both set, dmem_addr=0x0010, dmem_we=0, word4=0x12345678 -> dmem_busy=0, imem_busy=1, mem_addr=4; dmem_rdata=0x12345678 next cycle; imem_data unchanged.
- Both ports requesting continuously with STARVE_MAX=4 -> DMEM wins cycles 0-3, IMEM wins cycle 4, imem_busy low only in cycle 4; counter restarts and the pattern repeats.
- dmem write dmem_addr=0x0004, dmem_we=4'b0011, wdata=0xAABBCCDD over word1=0x11223344 -> mem_we=0011; later read returns 0x1122CCDD; dmem_rdata unchanged by the write.
- Fetch granted in cycle N with imem_reset=1 in cycle N+1 -> imem_data=0 at N+2 instead of the fetched word.
- rst pulsed for one cycle during a pending DMEM read -> dmem_rdata=0 after reset; mem_en=0 during rst; address 0x10008 aliases to word 2 (ADDR_W=14).

Source files
------------

// File: rtl/ceespu_pkg.sv
// Shared encodings for the ceespu memory arbiter: per-cycle grant and the
// registered return-path selector.
package ceespu_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 14;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_IMEM,
    SEL_DMEM
  } grant_e;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_IMEM,
    GNT_IMEM_KILL,
    GNT_DMEM_RD,
    GNT_DMEM_WR
  } grant_q_e;

endpackage

// File: rtl/ceespu_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port lost a conflict.
module ceespu_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W0   = $clog2(MAX + 1);
  localparam int unsigned W    = (W0 < 3) ? 3 : W0;
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != MAXV))
      cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == MAXV);

endmodule

// File: rtl/ceespu_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the ceespu fetch and
// data ports, steering the one-cycle-latency read data back to the winner.
module ceespu_mem_arbiter
  import ceespu_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       imem_addr,
  input  logic              imem_en,
  input  logic              imem_reset,
  output logic [31:0]       imem_data,
  output logic              imem_busy,
  input  logic [15:0]       dmem_addr,
  input  logic              dmem_en,
  input  logic [3:0]        dmem_we,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  grant_e   grant;
  grant_q_e grantQ;
  grant_q_e grantD;
  logic     starveAtMax;
  logic     unusedAddrBits;

  // Byte-lane bits and anything above the RAM size are deliberately dropped.
  assign unusedAddrBits = ^{imem_addr, dmem_addr};

  always_comb begin
    grant = SEL_NONE;
    if (!rst) begin
      if (imem_en && (!dmem_en || starveAtMax))
        grant = SEL_IMEM;
      else if (dmem_en)
        grant = SEL_DMEM;
    end
  end

  assign imem_busy = imem_en && !rst && (grant != SEL_IMEM);
  assign dmem_busy = dmem_en && !rst && (grant != SEL_DMEM);

  assign mem_en    = (grant != SEL_NONE);
  assign mem_we    = (grant == SEL_DMEM) ? dmem_we : '0;
  assign mem_wdata = dmem_wdata;
  assign mem_addr  = (grant == SEL_IMEM) ? imem_addr[ADDR_W+1:2]
                                         : dmem_addr[ADDR_W+1:2];

  always_comb begin
    grantD = GNT_NONE;
    unique case (grant)
      SEL_IMEM: grantD = imem_reset ? GNT_IMEM_KILL : GNT_IMEM;
      SEL_DMEM: grantD = (dmem_we == '0) ? GNT_DMEM_RD : GNT_DMEM_WR;
      default:  grantD = GNT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      grantQ <= GNT_NONE;
    else
      grantQ <= grantD;
  end

  // imem_reset wins over a fetch return arriving at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_data  <= '0;
      dmem_rdata <= '0;
    end else begin
      if (imem_reset)
        imem_data <= '0;
      else if (grantQ == GNT_IMEM)
        imem_data <= mem_rdata;
      if (grantQ == GNT_DMEM_RD)
        dmem_rdata <= mem_rdata;
    end
  end

  ceespu_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (imem_en && (grant == SEL_DMEM)),
    .clr    ((grant == SEL_IMEM) || !imem_en),
    .at_max (starveAtMax)
  );

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Directed bench for ceespu_mem_arbiter with a behavioural byte-write RAM.
module tb_ceespu_mem_arbiter;

  localparam int unsigned ADDR_W = 14;

  logic              clk;
  logic              rst;
  logic [15:0]       imem_addr;
  logic              imem_en;
  logic              imem_reset;
  logic [31:0]       imem_data;
  logic              imem_busy;
  logic [15:0]       dmem_addr;
  logic              dmem_en;
  logic [3:0]        dmem_we;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  ceespu_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_reset (imem_reset),
    .imem_data  (imem_data),
    .imem_busy  (imem_busy),
    .dmem_addr  (dmem_addr),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_busy  (dmem_busy),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded while rst is high; read-before-write, one cycle latency.
  always @(posedge clk) begin
    if (rst) begin
      ram[1] <= 32'h11223344;
      ram[2] <= 32'hDEADBEEF;
      ram[4] <= 32'h12345678;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic idle();
    imem_en = 1'b0; dmem_en = 1'b0; dmem_we = 4'h0; imem_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_en = 1'b1; dmem_en = 1'b1; dmem_we = 4'hF; imem_reset = 1'b0;
    imem_addr = 16'h0008; dmem_addr = 16'h0010; dmem_wdata = 32'h0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL rst_mem_we: got %h want 0", mem_we); end
    checks++; if (imem_busy !== 1'b0 || dmem_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b%b want 00", imem_busy, dmem_busy); end
    repeat (2) @(negedge clk);
    checks++; if (imem_data !== 32'h0 || dmem_rdata !== 32'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0/0", imem_data, dmem_rdata); end
  endtask

  task automatic test_fetch();
    rst = 1'b0; idle(); imem_en = 1'b1; imem_addr = 16'h0008;
    #1;
    checks++; if (mem_addr !== 14'd2 || mem_en !== 1'b1) begin errors++; $display("FAIL fetch_addr: got %0d en=%b want 2 en=1", mem_addr, mem_en); end
    checks++; if (imem_busy !== 1'b0) begin errors++; $display("FAIL fetch_busy: got %b want 0", imem_busy); end
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (imem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data: got %h want deadbeef", imem_data); end
  endtask

  task automatic test_conflict();
    imem_en = 1'b1; imem_addr = 16'h0004; dmem_en = 1'b1; dmem_addr = 16'h0010; dmem_we = 4'h0;
    #1;
    checks++; if (dmem_busy !== 1'b0 || imem_busy !== 1'b1) begin errors++; $display("FAIL conflict_busy: got i=%b d=%b want i=1 d=0", imem_busy, dmem_busy); end
    checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL conflict_addr: got %0d want 4", mem_addr); end
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (dmem_rdata !== 32'h12345678) begin errors++; $display("FAIL conflict_rdata: got %h want 12345678", dmem_rdata); end
    checks++; if (imem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_imem_hold: got %h want deadbeef", imem_data); end
  endtask

  task automatic test_starve();
    logic expIBusy;
    imem_en = 1'b1; imem_addr = 16'h0004; dmem_en = 1'b1; dmem_addr = 16'h0010; dmem_we = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      expIBusy = (i % 5) != 4;
      checks++; if (imem_busy !== expIBusy || dmem_busy !== !expIBusy) begin errors++; $display("FAIL starve_busy[%0d]: got i=%b d=%b want i=%b d=%b", i, imem_busy, dmem_busy, expIBusy, !expIBusy); end
      checks++; if (mem_addr !== (expIBusy ? 14'd4 : 14'd1)) begin errors++; $display("FAIL starve_addr[%0d]: got %0d want %0d", i, mem_addr, expIBusy ? 4 : 1); end
      if (i == 5) begin
        checks++; if (imem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_imem_early: got %h want deadbeef", imem_data); end
      end
      if (i == 6) begin
        checks++; if (imem_data !== 32'h11223344) begin errors++; $display("FAIL starve_imem_data: got %h want 11223344", imem_data); end
      end
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    checks++; if (dmem_rdata !== 32'h12345678) begin errors++; $display("FAIL starve_dmem_data: got %h want 12345678", dmem_rdata); end
  endtask

  task automatic test_write();
    dmem_en = 1'b1; dmem_addr = 16'h0004; dmem_we = 4'b0011; dmem_wdata = 32'hAABBCCDD;
    #1;
    checks++; if (mem_we !== 4'b0011 || mem_addr !== 14'd1) begin errors++; $display("FAIL write_drive: got we=%b addr=%0d want we=0011 addr=1", mem_we, mem_addr); end
    checks++; if (mem_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL write_wdata: got %h want aabbccdd", mem_wdata); end
    @(negedge clk); dmem_we = 4'h0;
    #1;
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL read_we: got %b want 0000", mem_we); end
    @(negedge clk); idle();
    checks++; if (dmem_rdata !== 32'h12345678) begin errors++; $display("FAIL write_no_update: got %h want 12345678", dmem_rdata); end
    @(negedge clk);
    checks++; if (dmem_rdata !== 32'h1122CCDD) begin errors++; $display("FAIL write_readback: got %h want 1122ccdd", dmem_rdata); end
  endtask

  task automatic test_imem_reset();
    imem_en = 1'b1; imem_addr = 16'h0008;
    @(negedge clk); idle(); imem_reset = 1'b1;
    @(negedge clk); idle();
    checks++; if (imem_data !== 32'h0) begin errors++; $display("FAIL ireset_pending: got %h want 0", imem_data); end
    imem_en = 1'b1; imem_addr = 16'h0004; imem_reset = 1'b1;
    #1;
    checks++; if (imem_busy !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 14'd1) begin errors++; $display("FAIL ireset_grant: got busy=%b en=%b addr=%0d want 0 1 1", imem_busy, mem_en, mem_addr); end
    @(negedge clk); idle();
    checks++; if (imem_data !== 32'h0) begin errors++; $display("FAIL ireset_clear: got %h want 0", imem_data); end
    @(negedge clk);
    checks++; if (imem_data !== 32'h0) begin errors++; $display("FAIL ireset_kill: got %h want 0", imem_data); end
  endtask

  task automatic test_rst_mid();
    logic [16:0] wide;
    dmem_en = 1'b1; dmem_addr = 16'h0010; dmem_we = 4'h0;
    @(negedge clk); rst = 1'b1; imem_en = 1'b1; dmem_en = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0 || imem_busy !== 1'b0 || dmem_busy !== 1'b0) begin errors++; $display("FAIL rstmid_comb: got en=%b ib=%b db=%b want 000", mem_en, imem_busy, dmem_busy); end
    @(negedge clk); rst = 1'b0; idle();
    checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_clear: got %h want 0", dmem_rdata); end
    @(negedge clk);
    checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_discard: got %h want 0", dmem_rdata); end
    wide = 17'h10008;
    imem_en = 1'b1; imem_addr = wide[15:0];
    #1;
    checks++; if (mem_addr !== 14'd2) begin errors++; $display("FAIL alias_addr: got %0d want 2", mem_addr); end
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (imem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_data: got %h want deadbeef", imem_data); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_starve();
    test_write();
    test_imem_reset();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
